// File: rtl/scalar_alu_arbiter_pkg.sv
// Shared types for the scalar ALU arbiter slice.
// Holds the ALU opcodes, the arbiter states and the flag bit positions.
package scalar_alu_pkg;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    PASS_A = 3'd1,
    ADD    = 3'd2,
    SUB    = 3'd3,
    MUL    = 3'd4,
    DIV    = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/scalar_alu_arbiter_alu.sv
// ALUScalar: shared N-bit scalar ALU, purely combinational.
// In: a, b, sel (alu_op_t). Out: c, flags {N,Z,V,C}.
module ALUScalar
  import scalar_alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_op_t      sel,
  output logic [N-1:0] c,
  output logic [3:0]   flags
);

  logic [N:0]     sum;
  logic [N:0]     dif;
  logic [2*N-1:0] prod;
  logic           v;
  logic           cy;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign dif  = {1'b0, a} - {1'b0, b};
  assign prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};

  // C is carry-out for ADD, borrow for SUB,
  // lost high product bits for MUL.
  // Divide by zero yields all ones with V set.
  always_comb begin
    c  = '0;
    v  = 1'b0;
    cy = 1'b0;
    unique case (1'b1)
      (sel == PASS_A): c = a;
      (sel == ADD): begin
        c  = sum[N-1:0];
        cy = sum[N];
        v  = (a[N-1] == b[N-1]) &&
             (sum[N-1] != a[N-1]);
      end
      (sel == SUB): begin
        c  = dif[N-1:0];
        cy = dif[N];
        v  = (a[N-1] != b[N-1]) &&
             (dif[N-1] != a[N-1]);
      end
      (sel == MUL): begin
        c  = prod[N-1:0];
        cy = |prod[2*N-1:N];
      end
      (sel == DIV): begin
        if (b == '0) begin
          c = '1;
          v = 1'b1;
        end else begin
          c = a / b;
        end
      end
      default: c = '0;
    endcase
  end

  assign flags = {c[N-1], ~|c, v, cy};

endmodule

// File: rtl/scalar_alu_arbiter_rr_grant.sv
// rr_grant: combinational one-hot grant from a valid vector.
// In: valid, ptr, rr_en. Out: gnt (one-hot), idx, any.
module rr_grant #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  input  logic            rr_en,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int   base;
  int   j;
  logic found;

  // Search starts just after the last winner in
  // round-robin mode, at index 0 otherwise.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    base  = rr_en ? (int'(ptr) + 1) % NREQ : 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (base + k) % NREQ;
      if (!found && valid[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  assign any = |valid;

endmodule

// File: rtl/scalar_alu_arbiter.sv
// scalar_alu_arbiter: shares one ALUScalar among NREQ requesters.
// Ports: req_valid/ready/a/b/sel per requester; rsp_valid/ready/c/flags/id; busy.
// Define SCALAR_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module scalar_alu_arbiter
  import scalar_alu_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][N-1:0]   req_a,
  input  logic [NREQ-1:0][N-1:0]   req_b,
  input  logic [NREQ-1:0][2:0]     req_sel,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [N-1:0]             rsp_c,
  output logic [3:0]               rsp_flags,
  output logic [IW-1:0]            rsp_id,
  output logic                     busy
);

  arb_state_t      state;
  logic [N-1:0]    op_a;
  logic [N-1:0]    op_b;
  alu_op_t         op_sel;
  logic [IW-1:0]   op_id;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic [N-1:0]    alu_c;
  logic [3:0]      alu_f;

`ifdef SCALAR_ARB_ROUND_ROBIN_EN
  localparam logic RR = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IW'(NREQ - 1);
    end else if (state == IDLE && any) begin
      ptr <= gidx;
    end
  end
`else
  localparam logic RR = 1'b0;

  assign ptr = '0;
`endif

  rr_grant #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_grant (
    .valid (req_valid),
    .ptr   (ptr),
    .rr_en (RR),
    .gnt   (gnt),
    .idx   (gidx),
    .any   (any)
  );

  ALUScalar #(
    .N (N)
  ) u_alu (
    .a     (op_a),
    .b     (op_b),
    .sel   (op_sel),
    .c     (alu_c),
    .flags (alu_f)
  );

  // Grant is the accept pulse of the IDLE cycle;
  // held off while reset is asserted.
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_sel    <= ZERO;
      op_id     <= '0;
      rsp_c     <= '0;
      rsp_flags <= '0;
      rsp_id    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            op_a   <= req_a[gidx];
            op_b   <= req_b[gidx];
            op_sel <= alu_op_t'(req_sel[gidx]);
            op_id  <= gidx;
            state  <= EXEC;
          end
        end
        EXEC: begin
          rsp_c     <= alu_c;
          rsp_flags <= alu_f;
          rsp_id    <= op_id;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
